// File: rtl/bonus_scheduler.sv
// Frame-tick scheduler for the bullet-supply drop: opens the spawner window, closes it on pickup,
// and runs the double-fire power timer. Define BONUS_SCHED_STACK_EN to stack pickups with saturation.
module bonus_scheduler #(
  parameter int unsigned WAIT_BASE    = 600,
  parameter int unsigned RAND_W       = 8,
  parameter int unsigned SPAWN_FRAMES = 240,
  parameter int unsigned POWER_FRAMES = 600,
  parameter int unsigned CNT_W        = 12
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              game_en_i,
  input  logic              v_sync_i,
  input  logic [RAND_W-1:0] rand_i,
  input  logic              crash_me_bonus_i,
  output logic              supply_en_o,
  output logic              double_fire_o,
  output logic [CNT_W-1:0]  power_left_o,
  output logic [1:0]        state_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SPAWN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_pwr;
  logic [CNT_W-1:0] w_pwr_nxt;
  logic [CNT_W-1:0] w_wait_load;
  logic [CNT_W-1:0] w_pwr_load;
  logic             r_v_sync_d;
  logic             r_supply_en;
  logic             r_double_fire;
  logic             w_tick;
  logic             w_pickup;

  // One tick per rising edge of v_sync, however long it stays high.
  assign w_tick      = v_sync_i & ~r_v_sync_d;
  assign w_pickup    = crash_me_bonus_i;
  assign w_wait_load = CNT_W'(WAIT_BASE) + CNT_W'(rand_i);

`ifdef BONUS_SCHED_STACK_EN
  logic [SUM_W-1:0] w_pwr_sum;

  // Sum one bit wider than the timer so the overflow is visible for saturation.
  assign w_pwr_sum  = {1'b0, r_pwr} + SUM_W'(POWER_FRAMES);
  assign w_pwr_load = w_pwr_sum[CNT_W] ? {CNT_W{1'b1}} : w_pwr_sum[CNT_W-1:0];
`else
  assign w_pwr_load = CNT_W'(POWER_FRAMES);
`endif

  // State, counters and the registered output decodes.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pwr         <= '0;
      r_v_sync_d    <= 1'b0;
      r_supply_en   <= 1'b0;
      r_double_fire <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_pwr         <= w_pwr_nxt;
      r_v_sync_d    <= v_sync_i;
      r_supply_en   <= (w_state_nxt == S_SPAWN);
      r_double_fire <= (w_pwr_nxt != '0);
    end
  end

  // Next-state, window counter and power timer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pwr_nxt   = r_pwr;
    if (!game_en_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_pwr_nxt   = '0;
    end else begin
      // A pickup overrides any tick decrement of the power timer.
      if (w_pickup && (r_state != S_IDLE)) begin
        w_pwr_nxt = w_pwr_load;
      end else if (w_tick && (r_pwr != '0)) begin
        w_pwr_nxt = r_pwr - CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_wait_load;
        end
        S_WAIT: begin
          if (w_tick) begin
            if (r_cnt == CNT_W'(1)) begin
              w_state_nxt = S_SPAWN;
              w_cnt_nxt   = CNT_W'(SPAWN_FRAMES);
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        S_SPAWN: begin
          if (w_pickup) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = w_wait_load;
          end else if (w_tick) begin
            if (r_cnt == CNT_W'(1)) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = w_wait_load;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign supply_en_o   = r_supply_en;
  assign double_fire_o = r_double_fire;
  assign power_left_o  = r_pwr;
  assign state_o       = 2'(r_state);

endmodule

// File: tb/tb_bonus_scheduler.sv
// Self-checking bench for bonus_scheduler: directed scenarios plus randomized frames,
// every cycle compared against a behavioural model of the frame/pickup rules.
module tb_bonus_scheduler;

  localparam int WB = 3;
  localparam int RW = 2;
  localparam int SF = 2;
  localparam int PF = 4;
  localparam int CW = 4;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          vs;
  logic [RW-1:0] rnd;
  logic          pick;
  logic          supply;
  logic          dfire;
  logic [CW-1:0] pwr;
  logic [1:0]    state;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural reference: phase (0 idle, 1 waiting, 2 window open), ticks left, power frames left.
  int m_st;
  int m_cnt;
  int m_pwr;
  bit m_vsd;

  bonus_scheduler #(
    .WAIT_BASE(WB), .RAND_W(RW), .SPAWN_FRAMES(SF), .POWER_FRAMES(PF), .CNT_W(CW)
  ) dut (
    .clk_vga(clk),
    .rst(rst),
    .game_en_i(en),
    .v_sync_i(vs),
    .rand_i(rnd),
    .crash_me_bonus_i(pick),
    .supply_en_o(supply),
    .double_fire_o(dfire),
    .power_left_o(pwr),
    .state_o(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_pwr = 0; m_vsd = 1'b0;
  endtask

  task automatic model_edge();
    bit tick;
    int wait_len;
    int ns, nc, np;
    tick     = vs && !m_vsd;
    wait_len = WB + int'(rnd);
    ns = m_st; nc = m_cnt; np = m_pwr;
    if (!en) begin
      ns = 0; nc = 0; np = 0;
    end else begin
      if (pick && m_st != 0) begin
`ifdef BONUS_SCHED_STACK_EN
        np = (m_pwr + PF > PMAX) ? PMAX : m_pwr + PF;
`else
        np = PF;
`endif
      end else if (tick && m_pwr > 0) begin
        np = m_pwr - 1;
      end
      if (m_st == 0) begin
        ns = 1; nc = wait_len;
      end else if (m_st == 1) begin
        if (tick) begin
          if (m_cnt == 1) begin ns = 2; nc = SF; end
          else nc = m_cnt - 1;
        end
      end else if (m_st == 2) begin
        if (pick) begin
          ns = 1; nc = wait_len;
        end else if (tick) begin
          if (m_cnt == 1) begin ns = 1; nc = wait_len; end
          else nc = m_cnt - 1;
        end
      end else begin
        ns = 0; nc = 0;
      end
    end
    m_st = ns; m_cnt = nc; m_pwr = np; m_vsd = vs;
  endtask

  task automatic chk_all();
    chk("state", 32'(state), 32'(m_st));
    chk("supply_en", 32'(supply), 32'(m_st == 2));
    chk("double_fire", 32'(dfire), 32'(m_pwr != 0));
    chk("power_left", 32'(pwr), 32'(m_pwr));
  endtask

  task automatic step(input bit v, input bit p);
    @(negedge clk);
    vs = v; pick = p;
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  // One frame: v_sync high for two cycles then low for two, optional pickup on the tick cycle.
  task automatic frame(input bit p);
    step(1'b1, p);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    int exp_seq[10];
    int vleft;
    bit vcur;
    exp_seq = '{1, 1, 1, 2, 2, 1, 1, 1, 1, 2};
    rst = 1'b1; en = 1'b0; vs = 1'b0; pick = 1'b0; rnd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_supply", 32'(supply), 0);
    chk("rst_dfire", 32'(dfire), 0);
    chk("rst_pwr", 32'(pwr), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic cycle with rand 1: four ticks waiting, two ticks open.
    en = 1'b1; rnd = 2'd1;
    step(1'b0, 1'b0);
    chk("en_latency_state", 32'(state), 1);
    for (int k = 0; k < 10; k++) begin
      frame(1'b0);
      chk("basic_seq_state", 32'(state), 32'(exp_seq[k]));
      chk("basic_seq_supply", 32'(supply), 32'(exp_seq[k] == 2));
    end

    // Pickup while the window is open.
    step(1'b0, 1'b1);
    chk("pick_supply", 32'(supply), 0);
    chk("pick_state", 32'(state), 1);
    chk("pick_dfire", 32'(dfire), 1);
    chk("pick_pwr", 32'(pwr), 4);
    repeat (3) frame(1'b0);
    chk("pick_dfire_3ticks", 32'(dfire), 1);
    frame(1'b0);
    chk("pick_dfire_4ticks", 32'(dfire), 0);
    chk("pick_back_to_spawn", 32'(state), 2);

    // Pickup on the same edge as a tick, with two power frames left.
    step(1'b0, 1'b1);
    frame(1'b0);
    frame(1'b0);
    chk("pre_coinc_pwr", 32'(pwr), 2);
    step(1'b1, 1'b1);
`ifdef BONUS_SCHED_STACK_EN
    chk("coinc_pwr", 32'(pwr), 6);
`else
    chk("coinc_pwr", 32'(pwr), 4);
`endif
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
`ifdef BONUS_SCHED_STACK_EN
    chk("stack_pwr_14", 32'(pwr), 14);
`else
    chk("reload_pwr", 32'(pwr), 4);
`endif
    step(1'b1, 1'b1);
`ifdef BONUS_SCHED_STACK_EN
    chk("stack_saturate", 32'(pwr), 15);
`else
    chk("reload_pwr_tick", 32'(pwr), 4);
`endif
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Long v_sync high counts as one tick.
    en = 1'b0;
    step(1'b0, 1'b0);
    chk("disable_pwr", 32'(pwr), 0);
    en = 1'b1; rnd = 2'd1;
    step(1'b0, 1'b0);
    repeat (50) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("long_vs_state", 32'(state), 1);
    frame(1'b0);
    frame(1'b0);
    chk("long_vs_still_wait", 32'(state), 1);
    frame(1'b0);
    chk("long_vs_spawn", 32'(state), 2);

    // Disable during an open window with three power frames left.
    rnd = 2'd0;
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);
    step(1'b0, 1'b1);
    frame(1'b0);
    chk("pre_drop_state", 32'(state), 2);
    chk("pre_drop_pwr", 32'(pwr), 3);
    en = 1'b0;
    step(1'b0, 1'b0);
    chk("drop_state", 32'(state), 0);
    chk("drop_supply", 32'(supply), 0);
    chk("drop_pwr", 32'(pwr), 0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("idle_pick_pwr", 32'(pwr), 0);
    en = 1'b1;
    step(1'b0, 1'b1);
    chk("idle_en_pick_pwr", 32'(pwr), 0);
    chk("idle_en_pick_state", 32'(state), 1);

    // Asynchronous reset in the middle of a wait.
    frame(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_supply", 32'(supply), 0);
    chk("async_rst_dfire", 32'(dfire), 0);
    chk("async_rst_pwr", 32'(pwr), 0);
    rnd = 2'd3;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0);
    repeat (5) frame(1'b0);
    chk("post_rst_wait5", 32'(state), 1);
    frame(1'b0);
    chk("post_rst_spawn6", 32'(state), 2);

    // Randomized frames, pickups and occasional disables.
    vleft = 0;
    vcur  = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      en  = ($urandom_range(0, 149) != 0);
      rnd = 2'($urandom_range(0, 3));
      if (vleft == 0) begin
        vcur  = ~vcur;
        vleft = int'($urandom_range(1, 4));
      end
      vleft--;
      step(vcur, ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
